// File: rtl/pong_pkg.sv
// Shared types and screen/geometry constants for the Pong game controller.
// Geometry values are 11 bits wide so edge arithmetic never wraps before it is compared.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        PLAY,
        GAME_OVER
    } state_e;

    localparam logic [10:0] SCREEN_W     = 11'd640;
    localparam logic [10:0] SCREEN_H     = 11'd480;
    localparam logic [10:0] BALL_SIZE    = 11'd8;
    localparam logic [10:0] BALL_SPEED   = 11'd2;
    localparam logic [10:0] PADDLE_H     = 11'd64;
    localparam logic [10:0] PADDLE_W     = 11'd8;
    localparam logic [10:0] PADDLE_SPEED = 11'd4;
    localparam logic [10:0] P1_X         = 11'd16;
    localparam logic [10:0] P2_X         = 11'd616;
    localparam logic [10:0] PADDLE_Y_MAX = SCREEN_H - PADDLE_H;

    localparam int          SERVE_FRAMES = 60;
    localparam logic [5:0]  SERVE_LAST   = 6'(SERVE_FRAMES - 1);
    localparam logic [2:0]  WIN_SCORE    = 3'd7;

    localparam logic [9:0]  BALL_X0      = 10'd316;
    localparam logic [9:0]  BALL_Y0      = 10'd236;
    localparam logic [9:0]  PADDLE_Y0    = 10'd208;

endpackage

// File: rtl/pong_game_ctrl_paddle.sv
// One paddle: moves PADDLE_SPEED per frame tick while enabled, clamped to the screen.
// Both or neither button pressed holds the paddle still.
module pong_paddle_ctrl
    import pong_pkg::*;
(
    input  logic       clk50M,
    input  logic       reset,
    input  logic       tick,
    input  logic       enable,
    input  logic       up,
    input  logic       down,
    output logic [9:0] y
);

    logic [9:0]  r_y;
    logic [10:0] w_y;
    logic [10:0] w_up;
    logic [10:0] w_dn;

    // Bit 10 of w_up flags an underflow below row 0.
    assign w_y  = {1'b0, r_y};
    assign w_up = w_y - PADDLE_SPEED;
    assign w_dn = w_y + PADDLE_SPEED;
    assign y    = r_y;

    always_ff @(posedge clk50M) begin
        if (reset) begin
            r_y <= PADDLE_Y0;
        end else if (tick && enable) begin
            if (up && !down) begin
                r_y <= w_up[10] ? 10'd0 : w_up[9:0];
            end else if (down && !up) begin
                r_y <= (w_dn > PADDLE_Y_MAX) ? PADDLE_Y_MAX[9:0] : w_dn[9:0];
            end
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: synchronises frame and button inputs, runs the ball/score FSM
// once per frame tick and drives positions back to the graphics block.
module pong_game_ctrl
    import pong_pkg::*;
(
    input  logic       clk50M,
    input  logic       reset,
    input  logic       endofframe,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle_one_y,
    output logic [9:0] paddle_two_y,
    output logic [2:0] score_one,
    output logic [2:0] score_two,
    output logic       game_over,
    output logic       winner,
    output state_e     o_dbg_state
);

    localparam logic [9:0] P1_HIT_X   = 10'(P1_X + PADDLE_W);
    localparam logic [9:0] P2_HIT_X   = 10'(P2_X - BALL_SIZE);
    localparam logic [9:0] BALL_Y_MAX = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0] STEP       = 10'(BALL_SPEED);

    logic       r_eof_s1, r_eof_s2, r_eof_prev;
    logic [4:0] r_btn_s1, r_btn_s2;
    state_e     r_state;
    logic [5:0] r_serve_cnt;
    logic [9:0] r_ball_x, r_ball_y;
    logic       r_dx_neg, r_dy_neg;
    logic [2:0] r_score_one, r_score_two;
    logic       r_game_over, r_winner;

    logic        w_tick, w_start, w_restart, w_paddle_rst, w_paddle_en;
    logic [10:0] w_x, w_y, w_p1, w_p2;
    logic        w_hit1, w_hit2, w_miss_l, w_miss_r;
    logic [9:0]  w_ny;
    logic        w_ndy_neg;
    logic [2:0]  w_s1_inc, w_s2_inc;

    always_ff @(posedge clk50M) begin
        if (reset) begin
            r_eof_s1   <= 1'b0;
            r_eof_s2   <= 1'b0;
            r_eof_prev <= 1'b0;
            r_btn_s1   <= '0;
            r_btn_s2   <= '0;
        end else begin
            r_eof_s1   <= endofframe;
            r_eof_s2   <= r_eof_s1;
            r_eof_prev <= r_eof_s2;
            r_btn_s1   <= {p2_down, p2_up, p1_down, p1_up, start};
            r_btn_s2   <= r_btn_s1;
        end
    end

    // Start is acted on between frames so a short button press is never lost.
    assign w_tick       = r_eof_s2 & ~r_eof_prev;
    assign w_start      = r_btn_s2[0];
    assign w_restart    = (r_state == GAME_OVER) && w_start;
    assign w_paddle_rst = reset | w_restart;
    assign w_paddle_en  = (r_state == SERVE) || (r_state == PLAY);

    pong_paddle_ctrl u_paddle_one (
        .clk50M (clk50M),
        .reset  (w_paddle_rst),
        .tick   (w_tick),
        .enable (w_paddle_en),
        .up     (r_btn_s2[1]),
        .down   (r_btn_s2[2]),
        .y      (paddle_one_y)
    );

    pong_paddle_ctrl u_paddle_two (
        .clk50M (clk50M),
        .reset  (w_paddle_rst),
        .tick   (w_tick),
        .enable (w_paddle_en),
        .up     (r_btn_s2[3]),
        .down   (r_btn_s2[4]),
        .y      (paddle_two_y)
    );

    assign w_x  = {1'b0, r_ball_x};
    assign w_y  = {1'b0, r_ball_y};
    assign w_p1 = {1'b0, paddle_one_y};
    assign w_p2 = {1'b0, paddle_two_y};

    assign w_hit1 = r_dx_neg && (w_x >= P1_X + PADDLE_W) && (w_x - BALL_SPEED <= P1_X + PADDLE_W)
                    && (w_y + BALL_SIZE > w_p1) && (w_y < w_p1 + PADDLE_H);
    assign w_hit2 = !r_dx_neg && (w_x + BALL_SIZE <= P2_X) && (w_x + BALL_SIZE + BALL_SPEED >= P2_X)
                    && (w_y + BALL_SIZE > w_p2) && (w_y < w_p2 + PADDLE_H);
    assign w_miss_l = r_dx_neg && (w_x < BALL_SPEED);
    assign w_miss_r = !r_dx_neg && (w_x + BALL_SIZE + BALL_SPEED > SCREEN_W);

    assign w_s1_inc = (r_score_one == WIN_SCORE) ? r_score_one : r_score_one + 3'd1;
    assign w_s2_inc = (r_score_two == WIN_SCORE) ? r_score_two : r_score_two + 3'd1;

    always_comb begin
        w_ny      = r_dy_neg ? r_ball_y - STEP : r_ball_y + STEP;
        w_ndy_neg = r_dy_neg;
        if (r_dy_neg && (w_y < BALL_SPEED)) begin
            w_ny      = 10'd0;
            w_ndy_neg = 1'b0;
        end else if (!r_dy_neg && (w_y + BALL_SIZE + BALL_SPEED > SCREEN_H)) begin
            w_ny      = BALL_Y_MAX;
            w_ndy_neg = 1'b1;
        end
    end

    always_ff @(posedge clk50M) begin
        if (reset) begin
            r_state     <= IDLE;
            r_serve_cnt <= '0;
            r_ball_x    <= BALL_X0;
            r_ball_y    <= BALL_Y0;
            r_dx_neg    <= 1'b0;
            r_dy_neg    <= 1'b0;
            r_score_one <= '0;
            r_score_two <= '0;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state     <= SERVE;
                        r_serve_cnt <= '0;
                    end
                end
                SERVE: begin
                    if (w_tick) begin
                        if (r_serve_cnt == SERVE_LAST) begin
                            r_state     <= PLAY;
                            r_serve_cnt <= '0;
                        end else begin
                            r_serve_cnt <= r_serve_cnt + 6'd1;
                        end
                    end
                end
                PLAY: begin
                    if (w_tick) begin
                        r_ball_y <= w_ny;
                        r_dy_neg <= w_ndy_neg;
                        if (w_hit1) begin
                            r_ball_x <= P1_HIT_X;
                            r_dx_neg <= 1'b0;
                        end else if (w_hit2) begin
                            r_ball_x <= P2_HIT_X;
                            r_dx_neg <= 1'b1;
                        end else if (w_miss_l || w_miss_r) begin
                            // A point recentres the ball; dy carries over, dx serves toward the loser.
                            r_ball_x    <= BALL_X0;
                            r_ball_y    <= BALL_Y0;
                            r_dy_neg    <= r_dy_neg;
                            r_dx_neg    <= w_miss_l;
                            r_serve_cnt <= '0;
                            if (w_miss_l) begin
                                r_score_two <= w_s2_inc;
                            end else begin
                                r_score_one <= w_s1_inc;
                            end
                            if ((w_miss_l ? w_s2_inc : w_s1_inc) == WIN_SCORE) begin
                                r_state     <= GAME_OVER;
                                r_game_over <= 1'b1;
                                r_winner    <= w_miss_l;
                            end else begin
                                r_state <= SERVE;
                            end
                        end else begin
                            r_ball_x <= r_dx_neg ? r_ball_x - STEP : r_ball_x + STEP;
                        end
                    end
                end
                GAME_OVER: begin
                    if (w_start) begin
                        r_state     <= SERVE;
                        r_serve_cnt <= '0;
                        r_score_one <= '0;
                        r_score_two <= '0;
                        r_ball_x    <= BALL_X0;
                        r_ball_y    <= BALL_Y0;
                        r_dx_neg    <= 1'b0;
                        r_game_over <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ball_x      = r_ball_x;
    assign ball_y      = r_ball_y;
    assign score_one   = r_score_one;
    assign score_two   = r_score_two;
    assign game_over   = r_game_over;
    assign winner      = r_winner;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: reset, serve timing and latency, paddle clamps,
// paddle hits, left miss, and a full game to WIN_SCORE with restart.
module tb_pong_game_ctrl;
    import pong_pkg::*;

    logic       clk50M = 1'b0;
    logic       reset = 1'b1;
    logic       endofframe = 1'b0;
    logic       start = 1'b0;
    logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
    logic [9:0] ball_x, ball_y, paddle_one_y, paddle_two_y;
    logic [2:0] score_one, score_two;
    logic       game_over, winner;
    state_e     dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    pong_game_ctrl dut (
        .clk50M       (clk50M),
        .reset        (reset),
        .endofframe   (endofframe),
        .start        (start),
        .p1_up        (p1_up),
        .p1_down      (p1_down),
        .p2_up        (p2_up),
        .p2_down      (p2_down),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .paddle_one_y (paddle_one_y),
        .paddle_two_y (paddle_two_y),
        .score_one    (score_one),
        .score_two    (score_two),
        .game_over    (game_over),
        .winner       (winner),
        .o_dbg_state  (dbg_state)
    );

    always #10 clk50M = ~clk50M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        check({tag, "_x"}, 32'(ball_x), ex);
        check({tag, "_y"}, 32'(ball_y), ey);
    endtask

    task automatic check_reset_vals(input string tag);
        check_pos(tag, 316, 236);
        check({tag, "_p1"}, 32'(paddle_one_y), 208);
        check({tag, "_p2"}, 32'(paddle_two_y), 208);
        check({tag, "_s1"}, 32'(score_one), 0);
        check({tag, "_s2"}, 32'(score_two), 0);
        check({tag, "_go"}, 32'(game_over), 0);
        check({tag, "_win"}, 32'(winner), 0);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    task automatic tick();
        endofframe = 1'b1;
        repeat (4) @(posedge clk50M);
        #1;
        endofframe = 1'b0;
        repeat (4) @(posedge clk50M);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk50M);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk50M);
        #1;
    endtask

    task automatic press_start();
        start = 1'b1;
        repeat (4) @(posedge clk50M);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk50M);
        #1;
    endtask

    // Serve with paddle two moved to 400 and paddle one raised by p1_ticks steps,
    // play until the ball bounces off paddle two and travels back to x = 26.
    task automatic run_rally(input int p1_ticks, input string tag);
        do_reset();
        press_start();
        p2_down = 1'b1;
        for (int i = 0; i < 48; i++) begin
            p1_up = (i < p1_ticks);
            tick();
        end
        p1_up = 1'b0;
        p2_down = 1'b0;
        ticks(12);
        check({tag, "_state_play"}, 32'(dbg_state), 32'(PLAY));
        check({tag, "_p1"}, 32'(paddle_one_y), 208 - 4 * p1_ticks);
        check({tag, "_p2"}, 32'(paddle_two_y), 400);
        ticks(145);
        check_pos({tag, "_approach"}, 606, 420);
        tick();
        check_pos({tag, "_p2_hit"}, 608, 418);
        ticks(291);
        check_pos({tag, "_left_run"}, 26, 162);
    endtask

    initial begin
        // Reset state
        do_reset();
        check_reset_vals("rst");

        // Serve timing and first-move latency
        press_start();
        check("serve_entry", 32'(dbg_state), 32'(SERVE));
        ticks(59);
        check_pos("serve_59", 316, 236);
        check("serve_59_state", 32'(dbg_state), 32'(SERVE));
        tick();
        check_pos("serve_60", 316, 236);
        check("serve_60_state", 32'(dbg_state), 32'(PLAY));
        endofframe = 1'b1;
        @(posedge clk50M); #1;
        check("lat_edge1_x", 32'(ball_x), 316);
        @(posedge clk50M); #1;
        check("lat_edge2_x", 32'(ball_x), 316);
        @(posedge clk50M); #1;
        check_pos("lat_edge3", 318, 238);
        endofframe = 1'b0;
        repeat (4) @(posedge clk50M);
        #1;
        ticks(5);
        check_pos("mid_play", 328, 248);

        // Reset mid-play takes effect on the next edge
        reset = 1'b1;
        @(posedge clk50M); #1;
        check_reset_vals("rst_mid");
        reset = 1'b0;
        repeat (2) @(posedge clk50M);
        #1;

        // Paddle clamps and button combinations
        press_start();
        p1_up = 1'b1;
        p2_down = 1'b1;
        tick();
        check("pad_p1_first", 32'(paddle_one_y), 204);
        check("pad_p2_first", 32'(paddle_two_y), 212);
        ticks(50);
        check("pad_p1_4", 32'(paddle_one_y), 4);
        check("pad_p2_412", 32'(paddle_two_y), 412);
        tick();
        check("pad_p1_top", 32'(paddle_one_y), 0);
        check("pad_p2_bottom", 32'(paddle_two_y), 416);
        tick();
        check("pad_p1_clamp", 32'(paddle_one_y), 0);
        check("pad_p2_clamp", 32'(paddle_two_y), 416);
        p1_down = 1'b1;
        p2_down = 1'b0;
        tick();
        check("pad_p1_both", 32'(paddle_one_y), 0);
        check("pad_p2_none", 32'(paddle_two_y), 416);
        p1_up = 1'b0;
        tick();
        check("pad_p1_down", 32'(paddle_one_y), 4);
        p1_down = 1'b0;

        // Paddle one hit
        run_rally(12, "hit");
        tick();
        check_pos("p1_hit", 24, 164);
        tick();
        check_pos("p1_rebound", 26, 166);

        // Paddle one out of the way: left miss scores for player two
        run_rally(0, "miss");
        tick();
        check_pos("p1_pass", 24, 164);
        tick();
        check_pos("p1_pass2", 22, 166);
        ticks(11);
        check_pos("left_edge", 0, 188);
        check("left_edge_s2", 32'(score_two), 0);
        tick();
        check("miss_l_s2", 32'(score_two), 1);
        check("miss_l_s1", 32'(score_one), 0);
        check_pos("miss_l_centre", 316, 236);
        check("miss_l_state", 32'(dbg_state), 32'(SERVE));

        // Full game: every rally is a right-side miss (219 ticks per point)
        do_reset();
        press_start();
        for (int p = 1; p <= 6; p++) begin
            ticks(219);
            check($sformatf("pt%0d_s1", p), 32'(score_one), p);
        end
        ticks(218);
        check("pre_win_s1", 32'(score_one), 6);
        check("pre_win_go", 32'(game_over), 0);
        check("pre_win_x", 32'(ball_x), 632);
        tick();
        check("win_s1", 32'(score_one), 7);
        check("win_s2", 32'(score_two), 0);
        check("win_go", 32'(game_over), 1);
        check("win_winner", 32'(winner), 0);
        check("win_state", 32'(dbg_state), 32'(GAME_OVER));
        check_pos("win_centre", 316, 236);
        p1_up = 1'b1;
        ticks(3);
        p1_up = 1'b0;
        check("frozen_p1", 32'(paddle_one_y), 208);
        check("frozen_s1", 32'(score_one), 7);
        check_pos("frozen", 316, 236);
        check("frozen_state", 32'(dbg_state), 32'(GAME_OVER));

        // Restart from GAME_OVER
        press_start();
        check("restart_s1", 32'(score_one), 0);
        check("restart_s2", 32'(score_two), 0);
        check("restart_go", 32'(game_over), 0);
        check("restart_state", 32'(dbg_state), 32'(SERVE));
        tick();
        check_pos("restart_serve", 316, 236);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-sequencing controller for Pong.
- Owns ball and paddle positions, ball direction, scores and game state.
- Advances the game once per video frame, using the `endofframe` output of the `graphics` block.
- Drives `ball_x`, `ball_y`, `paddle_one_y` and `paddle_two_y` back into `graphics`, so the display and game state stay frame-locked.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BALL_SIZE, 8, ball edge length in pixels
- BALL_SPEED, 2, ball step per frame on each axis
- PADDLE_H, 64, paddle height
- PADDLE_W, 8, paddle width
- PADDLE_SPEED, 4, paddle step per frame
- P1_X, 16, left x of paddle one
- P2_X, 616, left x of paddle two
- SERVE_FRAMES, 60, frames the ball is held at centre before play
- WIN_SCORE, 7, points needed to win

Ports:
- clk50M  in  1  system clock
- reset  in  1  synchronous, active-high reset
- endofframe  in  1  frame-end level from `graphics`; asynchronous to clk50M
- start  in  1  start/restart button
- p1_up, p1_down, p2_up, p2_down  in  1 each  paddle buttons
- ball_x, ball_y  out  10  ball top-left pixel
- paddle_one_y, paddle_two_y  out  10  paddle top pixel
- score_one, score_two  out  3  player scores
- game_over  out  1  high in GAME_OVER state
- winner  out  1  0 = player one won, 1 = player two won; valid while game_over

Behaviour:
- Clock and reset:
  - Single clock, clk50M.
  - Reset is synchronous and active-high; it is sampled only on the clk50M rising edge.
  - Reset overrides everything, including mid-play, and clears the serve counter.
- Reset values:
  - ball_x = 316, ball_y = 236 (centre).
  - paddles = 208.
  - scores = 0, game_over = 0, winner = 0, state = IDLE.
  - dx = +1, dy = +1.
- Input synchronisation:
  - endofframe and all buttons pass through 2-flop synchronisers.
  - frame_tick = sync_eof & ~prev_eof, a one-cycle pulse.
  - All game registers update only on the clock edge where frame_tick = 1.
  - Latency: outputs change exactly 3 clk50M edges after the first edge that samples endofframe high.
- State machine:
  - IDLE: on synchronised start = 1, go to SERVE; serve counter = 0.
  - SERVE:
    - Ball held at centre.
    - Each tick, the counter increments.
    - When counter = SERVE_FRAMES-1 on a tick, go to PLAY.
  - PLAY: ball moves each tick (rules below); start is ignored.
  - GAME_OVER:
    - Positions are frozen and game_over = 1.
    - start = 1 clears scores, recentres ball and paddles, sets dx = +1, and goes to SERVE.
- Paddles:
  - Update each tick in SERVE and PLAY only.
  - up only: y = max(0, y - PADDLE_SPEED).
  - down only: y = min(SCREEN_H - PADDLE_H, y + PADDLE_SPEED).
  - Both or neither pressed: hold.
  - Arithmetic is done at 11 bits so underflow and overflow are detected before clamping; no wrap-around.
- Ball motion (PLAY, per tick), evaluated in this priority order:
  1. Vertical:
     - If dy = -1 and y < BALL_SPEED: y = 0, dy = +1.
     - If dy = +1 and y + BALL_SIZE + BALL_SPEED > SCREEN_H: y = SCREEN_H - BALL_SIZE, dy = -1.
     - Otherwise y += dy*BALL_SPEED.
  2. Paddle one hit:
     - Condition: dx = -1, x >= P1_X + PADDLE_W, x - BALL_SPEED <= P1_X + PADDLE_W, and vertical overlap (y + BALL_SIZE > paddle_one_y and y < paddle_one_y + PADDLE_H).
     - Result: x = P1_X + PADDLE_W, dx = +1.
     - Overlap uses the pre-update paddle and ball positions.
  3. Paddle two hit (mirror):
     - Condition: dx = +1, x + BALL_SIZE <= P2_X, x + BALL_SIZE + BALL_SPEED >= P2_X, and vertical overlap with paddle two.
     - Result: x = P2_X - BALL_SIZE, dx = -1.
  4. Miss left:
     - Condition: dx = -1 and x < BALL_SPEED.
     - Player two scores; dx = -1 for the next serve (serve goes toward the loser).
  5. Miss right:
     - Condition: dx = +1 and x + BALL_SIZE + BALL_SPEED > SCREEN_W.
     - Player one scores; dx = +1.
  6. Otherwise x += dx*BALL_SPEED.
- On score:
  - Ball recentres and dy is kept.
  - If the new score = WIN_SCORE: go to GAME_OVER and set winner. Otherwise go to SERVE with counter = 0.
- A corner case (wall and paddle on the same tick) applies both the vertical and horizontal rules in the same tick.
- Scores saturate at WIN_SCORE and are never incremented in GAME_OVER.
- Every output is a register; no output is combinational.

Decomposition:
- Package pong_pkg:
  - State enum: IDLE, SERVE, PLAY, GAME_OVER.
  - Screen and geometry constants.
  - Centre-position constants (BALL_X0 = 316, BALL_Y0 = 236, PADDLE_Y0 = 208).
- Sub-module pong_paddle_ctrl:
  - Inputs: clk50M, reset, tick, enable, up, down.
  - Output: y.
  - Contains the clamp logic; instantiated twice.
- Synchronisers and the ball FSM stay in the top module.

Test Plan:
- Reset mid-PLAY with ball at (100,50) → next edge: ball (316,236), paddles 208, scores 0, state IDLE.
- start pulse, then 60 endofframe pulses → ball stays at (316,236) for 59 ticks; on tick 61 (the first PLAY tick), ball_x = 318 and ball_y = 238, 3 clk50M edges after endofframe rises.
- Paddle one at y = 2 with p1_up held → next tick y = 0, then stays 0. p1_up and p1_down both held → no change.
- Ball at (26,200), dx = -1, paddle_one_y = 180 → tick: x = 24, dx = +1. Same case with paddle_one_y = 300 → continues to x = 0 region, then score_two increments and ball recentres.
- Ball at y = 471, dy = +1 → y = 472, dy = -1. Ball at y = 1, dy = -1 → y = 0, dy = +1.
- score_one = 6 with a right-side miss → score_one = 7, game_over = 1, winner = 0, further ticks frozen. Then start → scores 0, state SERVE.
